// File: rtl/approx_mult_pkg.sv
// rtl/approx_mult_pkg.sv - shared types and elaboration helpers for approx_mult_seq
package approx_mult_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      LSHIFT = 3'd1,
      MULT   = 3'd2,
      RSHIFT = 3'd3,
      DONE   = 3'd4
   } state_t;

   // Width of a leading-zero count able to hold the value WIDTH itself.
   function automatic int cw_of(input int width);
      return $clog2(width + 1);
   endfunction

   function automatic int prod_w(input int trunc);
      return 2 * trunc;
   endfunction

   function automatic bit params_legal(input int width, input int trunc);
      return (width >= 4) && (trunc >= 2) && (trunc <= width);
   endfunction

endpackage

// File: rtl/approx_mult_seq_if.sv
// rtl/approx_mult_seq_if.sv - operand/result handshake bundle for approx_mult_seq
interface approx_mult_seq_if #(
   parameter int WIDTH = 16
);
   logic                 in_valid;
   logic                 in_ready;
   logic [WIDTH-1:0]     A;
   logic [WIDTH-1:0]     B;
   logic                 out_valid;
   logic                 out_ready;
   logic [2*WIDTH-1:0]   result;
   logic                 busy;

   modport master (
      output in_valid, A, B, out_ready,
      input  in_ready, out_valid, result, busy
   );

   modport slave (
      input  in_valid, A, B, out_ready,
      output in_ready, out_valid, result, busy
   );
endinterface

// File: rtl/approx_mult_seq_lzd_n.sv
// rtl/approx_mult_seq_lzd_n.sv - combinational leading-zero detector, returns WIDTH for zero input
module lzd_n
   import approx_mult_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int CW    = cw_of(WIDTH)
) (
   input  logic [WIDTH-1:0] x,
   output logic [CW-1:0]    lz
);

   // Scanning upward lets the highest set bit overwrite any lower hit.
   always_comb begin
      lz = CW'(WIDTH);
      for (int i = 0; i < WIDTH; i++) begin
         if (x[i]) begin
            lz = CW'(WIDTH - 1 - i);
         end
      end
   end

endmodule

// File: rtl/approx_mult_seq.sv
// rtl/approx_mult_seq.sv - sequential LZD/shift approximate multiplier; ZERO_BYPASS_EN skips zero operands
module approx_mult_seq
   import approx_mult_pkg::*;
#(
   parameter int WIDTH = 16,
   parameter int TRUNC = 8
) (
   input  logic               clk,
   input  logic               rst,
   approx_mult_seq_if.slave   bus
);

   localparam int CW = cw_of(WIDTH);
   localparam int PW = prod_w(TRUNC);
   localparam int SH = 2 * (WIDTH - TRUNC);

   if (!params_legal(WIDTH, TRUNC)) begin : g_param_check
      $error("approx_mult_seq: illegal WIDTH/TRUNC combination");
   end

   state_t              state_q, state_d;
   logic [WIDTH-1:0]    a_q, b_q;
   logic [CW-1:0]       la_c, lb_c, la_q, lb_q, ca_q, cb_q;
   logic [CW:0]         r_count, lz_sum;
   logic [2*WIDTH-1:0]  res_q, res_load;
   logic [PW-1:0]       product;
   logic                accept;

   lzd_n #(.WIDTH(WIDTH), .CW(CW)) u_lzd_a (.x(bus.A), .lz(la_c));
   lzd_n #(.WIDTH(WIDTH), .CW(CW)) u_lzd_b (.x(bus.B), .lz(lb_c));

   assign accept   = bus.in_valid && bus.in_ready;
   assign lz_sum   = {1'b0, la_q} + {1'b0, lb_q};
   assign product  = PW'(a_q[WIDTH-1 -: TRUNC]) * PW'(b_q[WIDTH-1 -: TRUNC]);
   assign res_load = (2*WIDTH)'(product) << SH;

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE: begin
            if (accept) begin
`ifdef ZERO_BYPASS_EN
               state_d = ((bus.A == '0) || (bus.B == '0)) ? DONE : LSHIFT;
`else
               state_d = LSHIFT;
`endif
            end
         end
         LSHIFT:  if ((ca_q == la_q) && (cb_q == lb_q)) state_d = MULT;
         MULT:    state_d = RSHIFT;
         RSHIFT:  if (r_count == lz_sum) state_d = DONE;
         DONE:    if (bus.out_ready) state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      bus.in_ready  = (state_q == IDLE) && !rst;
      bus.busy      = (state_q != IDLE);
      bus.out_valid = (state_q == DONE);
      bus.result    = res_q;
   end

   // Datapath: result register only moves in MULT/RSHIFT, so DONE holds it under backpressure.
   always_ff @(posedge clk) begin
      if (rst) begin
         a_q     <= '0;
         b_q     <= '0;
         la_q    <= '0;
         lb_q    <= '0;
         ca_q    <= '0;
         cb_q    <= '0;
         r_count <= '0;
         res_q   <= '0;
      end else begin
         case (state_q)
            IDLE: begin
               if (accept) begin
                  a_q     <= bus.A;
                  b_q     <= bus.B;
                  la_q    <= la_c;
                  lb_q    <= lb_c;
                  ca_q    <= '0;
                  cb_q    <= '0;
                  r_count <= '0;
`ifdef ZERO_BYPASS_EN
                  if ((bus.A == '0) || (bus.B == '0)) begin
                     res_q <= '0;
                  end
`endif
               end
            end
            LSHIFT: begin
               if (ca_q < la_q) begin
                  a_q  <= a_q << 1;
                  ca_q <= ca_q + CW'(1);
               end
               if (cb_q < lb_q) begin
                  b_q  <= b_q << 1;
                  cb_q <= cb_q + CW'(1);
               end
            end
            MULT: begin
               res_q   <= res_load;
               r_count <= '0;
            end
            RSHIFT: begin
               if (r_count < lz_sum) begin
                  res_q   <= res_q >> 1;
                  r_count <= r_count + (CW+1)'(1);
               end
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_approx_mult_seq.sv
// tb/tb_approx_mult_seq.sv - directed self-checking bench for approx_mult_seq
module tb_approx_mult_seq;

   localparam int WIDTH = 16;
   localparam int TRUNC = 8;
   localparam int MAX_WAIT = 200;

   logic clk;
   logic rst;
   int   checks;
   int   failures;

   approx_mult_seq_if #(.WIDTH(WIDTH)) bus ();

   approx_mult_seq #(.WIDTH(WIDTH), .TRUNC(TRUNC)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Accept one operand pair, wait for out_valid, optionally hold backpressure, then complete.
   task automatic run_op(input string tag, input logic [15:0] a, input logic [15:0] b,
                         input logic [31:0] exp_res, input int exp_lat, input bit hold);
      int          lat;
      logic [31:0] snap;
      bit          stable;
      @(negedge clk);
      bus.A         = a;
      bus.B         = b;
      bus.in_valid  = 1'b1;
      bus.out_ready = 1'b0;
      chk({tag, "_in_ready"}, 32'(bus.in_ready), 32'd1);
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      bus.A        = 16'h5A5A;
      bus.B        = 16'hA5A5;
      lat = 1;
      while (!bus.out_valid && lat < MAX_WAIT) begin
         @(posedge clk);
         #1;
         lat++;
      end
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_result"}, bus.result, exp_res);
      if (hold) begin
         snap   = bus.result;
         stable = 1'b1;
         for (int i = 0; i < 10; i++) begin
            bus.in_valid = 1'b1;
            bus.A        = 16'h1111 + 16'(i);
            bus.B        = 16'h0001;
            @(posedge clk);
            #1;
            if (!bus.out_valid || bus.result !== snap || !bus.busy) stable = 1'b0;
         end
         bus.in_valid = 1'b0;
         chk({tag, "_bp_stable"}, 32'(stable), 32'd1);
         chk({tag, "_bp_result"}, bus.result, exp_res);
      end
      bus.out_ready = 1'b1;
      @(posedge clk);
      #1;
      bus.out_ready = 1'b0;
      chk({tag, "_post_out_valid"}, 32'(bus.out_valid), 32'd0);
      chk({tag, "_post_in_ready"}, 32'(bus.in_ready), 32'd1);
   endtask

   initial begin
      checks        = 0;
      failures      = 0;
      rst           = 1'b1;
      bus.in_valid  = 1'b0;
      bus.out_ready = 1'b0;
      bus.A         = '0;
      bus.B         = '0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
      chk("rst_busy", 32'(bus.busy), 32'd0);
      chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("rst_result", bus.result, 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("rst_release_in_ready", 32'(bus.in_ready), 32'd1);

      run_op("norm", 16'h8000, 16'h8000, 32'h4000_0000, 4, 1'b0);
      run_op("small", 16'h0003, 16'h0005, 32'h0000_000F, 45, 1'b0);
      run_op("trunc", 16'hFFFF, 16'hFFFF, 32'hFE01_0000, 4, 1'b1);

      // Reset while the result register is mid right-shift.
      @(negedge clk);
      bus.A        = 16'h0001;
      bus.B        = 16'h0001;
      bus.in_valid = 1'b1;
      @(posedge clk);
      #1;
      bus.in_valid = 1'b0;
      repeat (19) @(posedge clk);
      #1;
      chk("midrst_busy_before", 32'(bus.busy), 32'd1);
      rst = 1'b1;
      @(posedge clk);
      #1;
      chk("midrst_out_valid", 32'(bus.out_valid), 32'd0);
      chk("midrst_busy", 32'(bus.busy), 32'd0);
      chk("midrst_result", bus.result, 32'd0);
      chk("midrst_in_ready", 32'(bus.in_ready), 32'd0);
      rst = 1'b0;
      @(posedge clk);
      #1;
      chk("midrst_release_in_ready", 32'(bus.in_ready), 32'd1);
      run_op("after_rst", 16'h8000, 16'h8000, 32'h4000_0000, 4, 1'b0);

`ifdef ZERO_BYPASS_EN
      run_op("zero_a", 16'h0000, 16'h1234, 32'd0, 1, 1'b0);
      run_op("zero_a_msb_b", 16'h0000, 16'h8000, 32'd0, 1, 1'b0);
`else
      run_op("zero_a", 16'h0000, 16'h1234, 32'd0, 39, 1'b0);
      run_op("zero_a_msb_b", 16'h0000, 16'h8000, 32'd0, 36, 1'b0);
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
